// File: rtl/benes_cfg_ctrl_if.sv
// Host-side configuration, commit and input-admission signals of the Benes config controller.
// The master modport is the host / upstream side; the slave modport is the controller.
interface benes_cfg_ctrl_if #(
    parameter int N_STAGES     = 7,
    parameter int SW_PER_STAGE = 8,
    parameter int STG_W        = 3
);
    logic                             cfg_valid;
    logic                             cfg_ready;
    logic [STG_W-1:0]                 cfg_stage;
    logic [SW_PER_STAGE-1:0]          cfg_bits;
    logic                             cfg_err;
    logic                             commit_req;
    logic                             commit_ack;
    logic                             in_valid;
    logic                             in_stall;
    logic [N_STAGES*SW_PER_STAGE-1:0] switch_set_flat;
    logic [3:0]                       cfg_epoch;
    logic                             busy;

    modport master (
        output cfg_valid, cfg_stage, cfg_bits, commit_req, in_valid,
        input  cfg_ready, cfg_err, commit_ack, in_stall, switch_set_flat, cfg_epoch, busy
    );

    modport slave (
        input  cfg_valid, cfg_stage, cfg_bits, commit_req, in_valid,
        output cfg_ready, cfg_err, commit_ack, in_stall, switch_set_flat, cfg_epoch, busy
    );
endinterface

// File: rtl/benes_cfg_ctrl.sv
// Shadow/active configuration controller for the registered Benes stage pipeline:
// a commit stalls input, waits for the pipe to empty, then swaps shadow into active in one edge.
module benes_cfg_ctrl #(
    parameter int N_STAGES     = 7,
    parameter int SW_PER_STAGE = 8,
    parameter int STAGE_LAT    = 1,
    parameter int STG_W        = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    benes_cfg_ctrl_if.slave       bus
);
    localparam int L      = N_STAGES * STAGE_LAT;
    localparam int FLAT_W = N_STAGES * SW_PER_STAGE;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SWAP  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t              state_r;
    logic [L-1:0]        occ_r;
    logic [FLAT_W-1:0]   shadow_r;
    logic [FLAT_W-1:0]   active_r;
    logic [3:0]          epoch_r;
    logic                cfg_err_r;
    logic                cfg_ready_r;
    logic                commit_ack_r;
    logic                in_stall_r;
    logic                busy_r;
    logic                admit_s;

    assign admit_s = bus.in_valid & ~in_stall_r;

    // One bit per pipeline register cycle: set while an admitted word is still inside the stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_r <= '0;
        end else begin
            occ_r <= (occ_r << 1) | L'(admit_s);
        end
    end

    // Commit sequencing, shadow writes and the handshake outputs, all loaded for the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            shadow_r     <= '0;
            active_r     <= '0;
            epoch_r      <= 4'd0;
            cfg_err_r    <= 1'b0;
            cfg_ready_r  <= 1'b1;
            commit_ack_r <= 1'b0;
            in_stall_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // A write in the commit cycle lands before the swap, so it is part of this commit
                    if (bus.cfg_valid && cfg_ready_r) begin
                        if (int'(bus.cfg_stage) < N_STAGES) begin
                            for (int s = 0; s < N_STAGES; s++) begin
                                if (bus.cfg_stage == STG_W'(s)) begin
                                    shadow_r[s*SW_PER_STAGE +: SW_PER_STAGE] <= bus.cfg_bits;
                                end
                            end
                        end else begin
                            cfg_err_r <= 1'b1;
                        end
                    end
                    if (bus.commit_req) begin
                        state_r     <= DRAIN;
                        cfg_ready_r <= 1'b0;
                        in_stall_r  <= 1'b1;
                        busy_r      <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (occ_r == '0) begin
                        state_r <= SWAP;
                    end
                end
                SWAP: begin
                    state_r      <= ACK;
                    active_r     <= shadow_r;
                    epoch_r      <= epoch_r + 4'd1;
                    commit_ack_r <= 1'b1;
                end
                ACK: begin
                    state_r      <= IDLE;
                    commit_ack_r <= 1'b0;
                    cfg_ready_r  <= 1'b1;
                    in_stall_r   <= 1'b0;
                    busy_r       <= 1'b0;
                    cfg_err_r    <= 1'b0;
                end
                default: begin
                    state_r      <= IDLE;
                    commit_ack_r <= 1'b0;
                    cfg_ready_r  <= 1'b1;
                    in_stall_r   <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cfg_ready       = cfg_ready_r;
    assign bus.cfg_err         = cfg_err_r;
    assign bus.commit_ack      = commit_ack_r;
    assign bus.in_stall        = in_stall_r;
    assign bus.busy            = busy_r;
    assign bus.switch_set_flat = active_r;
    assign bus.cfg_epoch       = epoch_r;
endmodule
